// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run/step/drain controller for an N-stage pipeline
// Optional breakpoint unit enabled by defining PIPE_CTRL_BKPT_EN.
module pipeline_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int STALL_LATCH = 0,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_BITS    = 32
`ifdef PIPE_CTRL_BKPT_EN
  , parameter int PC_BITS   = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic                  i_stall_req,
  input  logic                  i_flush_req,
  input  logic                  i_halt_req,
`ifdef PIPE_CTRL_BKPT_EN
  input  logic                  i_bkpt_en,
  input  logic [PC_BITS-1:0]    i_bkpt_addr,
  input  logic [PC_BITS-1:0]    i_fetch_pc,
  output logic                  o_bkpt_hit,
`endif
  output logic                  o_pc_write,
  output logic [NUM_STAGES-2:0] o_latch_en,
  output logic [NUM_STAGES-2:0] o_latch_flush,
  output logic [NUM_STAGES-2:0] o_valid,
  output logic [2:0]            o_state,
  output logic [CNT_BITS-1:0]   o_cycle_count,
  output logic                  o_done
);

  localparam int L = NUM_STAGES - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [L-1:0]  r_valid, w_valid_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic          w_adv, w_stl, w_halt_q, w_clr, w_brk;

`ifdef PIPE_CTRL_BKPT_EN
  logic r_first, r_bkpt_hit;
  // The first advance after leaving IDLE ignores a match so a resume does not re-break.
  assign w_brk = (r_state == S_RUN) & i_bkpt_en & (i_fetch_pc == i_bkpt_addr) & ~r_first;
`else
  assign w_brk = 1'b0;
`endif

  assign w_adv    = ((r_state == S_RUN) | (r_state == S_STEP) | (r_state == S_DRAIN)) & ~w_brk;
  assign w_stl    = w_adv & i_stall_req & ~i_flush_req;
  assign w_halt_q = i_halt_req & ~i_flush_req;

  assign o_pc_write    = w_adv & ~w_stl & (r_state != S_DRAIN);
  assign o_valid       = r_valid;
  assign o_state       = r_state;
  assign o_cycle_count = r_cnt;
  assign o_done        = (r_state == S_DONE);

  always_comb begin
    o_latch_en    = '0;
    o_latch_flush = '0;
    for (int k = 0; k < L; k++) begin
      o_latch_en[k]    = w_adv & ~(w_stl & (k <= STALL_LATCH));
      o_latch_flush[k] = w_adv & ((i_flush_req & (k < FLUSH_DEPTH)) |
                                  (w_stl & (k == STALL_LATCH + 1)));
    end
  end

  // Shift, then hold the stalled latches, then apply flush/bubble clears.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_adv) begin
      w_valid_nxt[0] = (r_state != S_DRAIN);
      for (int k = 1; k < L; k++) begin
        w_valid_nxt[k] = r_valid[k-1];
      end
      for (int k = 0; k < L; k++) begin
        if (w_stl && (k <= STALL_LATCH)) begin
          w_valid_nxt[k] = r_valid[k];
        end
      end
      w_valid_nxt = w_valid_nxt & ~o_latch_flush;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = i_clear;
        if (i_run) begin
          w_state_nxt = S_RUN;
        end else if (i_step) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN: begin
        if (w_brk) begin
          w_state_nxt = S_IDLE;
        end else if (w_halt_q) begin
          w_state_nxt = S_DRAIN;
        end else if (!i_run) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        w_state_nxt = w_halt_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (w_adv && (w_valid_nxt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_clear) begin
          w_clr       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_valid <= '0;
        r_cnt   <= '0;
      end else begin
        r_valid <= w_valid_nxt;
        if (w_adv && (r_cnt != {CNT_BITS{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef PIPE_CTRL_BKPT_EN
  assign o_bkpt_hit = r_bkpt_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first    <= 1'b0;
      r_bkpt_hit <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (i_run || i_step)) begin
        r_first    <= 1'b1;
        r_bkpt_hit <= 1'b0;
      end else begin
        if (w_adv) begin
          r_first <= 1'b0;
        end
        if (w_brk) begin
          r_bkpt_hit <= 1'b1;
        end else if (w_clr) begin
          r_bkpt_hit <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
// Breakpoint scenario is built only when PIPE_CTRL_BKPT_EN is defined.
module tb_pipeline_ctrl;
  localparam int L  = 4;
  localparam int SL = 0;
  localparam int FD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_run = 1'b0, i_step = 1'b0, i_clear = 1'b0;
  logic i_stall_req = 1'b0, i_flush_req = 1'b0, i_halt_req = 1'b0;
  logic         o_pc_write, o_done;
  logic [L-1:0] o_latch_en, o_latch_flush, o_valid;
  logic [2:0]   o_state;
  logic [31:0]  o_cycle_count;
`ifdef PIPE_CTRL_BKPT_EN
  logic        i_bkpt_en = 1'b0;
  logic [31:0] i_bkpt_addr = 32'h0;
  logic [31:0] i_fetch_pc = 32'h0;
  logic        o_bkpt_hit;
`endif

  int errors = 0;
  int checks = 0;

  int           m_state, n_state;
  logic [L-1:0] m_valid, n_valid, e_en, e_fl;
  logic [31:0]  m_cnt, n_cnt;
  logic         e_pc;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
    .i_stall_req(i_stall_req), .i_flush_req(i_flush_req), .i_halt_req(i_halt_req),
`ifdef PIPE_CTRL_BKPT_EN
    .i_bkpt_en(i_bkpt_en), .i_bkpt_addr(i_bkpt_addr), .i_fetch_pc(i_fetch_pc),
    .o_bkpt_hit(o_bkpt_hit),
`endif
    .o_pc_write(o_pc_write), .o_latch_en(o_latch_en), .o_latch_flush(o_latch_flush),
    .o_valid(o_valid), .o_state(o_state), .o_cycle_count(o_cycle_count), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic set_in(input bit run, input bit step, input bit clr,
                        input bit stall, input bit flush, input bit halt);
    i_run = run; i_step = step; i_clear = clr;
    i_stall_req = stall; i_flush_req = flush; i_halt_req = halt;
  endtask

  task automatic tick();
`ifdef PIPE_CTRL_BKPT_EN
    bit pw;
    pw = o_pc_write;
    @(posedge clk); #1;
    if (pw) i_fetch_pc = i_fetch_pc + 1;
`else
    @(posedge clk); #1;
`endif
  endtask

  // Reference: valid bits as a shift word, stall mask, flush mask, state as 0..4.
  task automatic model_eval();
    bit adv, stl;
    logic [L-1:0] all, hold, nv;
    all  = '1;
    hold = L'((1 << (SL + 1)) - 1);
    adv  = (m_state >= 1) && (m_state <= 3);
    stl  = adv && i_stall_req && !i_flush_req;
    e_pc = adv && !stl && (m_state != 3);
    e_en = adv ? (stl ? (all & ~hold) : all) : '0;
    e_fl = adv ? ((i_flush_req ? L'((1 << FD) - 1) : L'(0)) | (stl ? L'(1 << (SL + 1)) : L'(0))) : '0;
    nv = m_valid;
    n_cnt = m_cnt;
    n_state = m_state;
    if (adv) begin
      nv = (m_valid << 1) | L'(m_state != 3);
      if (stl) nv = (nv & ~hold) | (m_valid & hold);
      nv = nv & ~e_fl;
      if (m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
    end
    case (m_state)
      0: begin
        if (i_clear) begin nv = '0; n_cnt = 0; end
        n_state = i_run ? 1 : (i_step ? 2 : 0);
      end
      1: n_state = (i_halt_req && !i_flush_req) ? 3 : (i_run ? 1 : 0);
      2: n_state = (i_halt_req && !i_flush_req) ? 3 : 0;
      3: n_state = (nv == '0) ? 4 : 3;
      default: if (i_clear) begin n_state = 0; nv = '0; n_cnt = 0; end
    endcase
    n_valid = nv;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_state = 0; m_valid = '0; m_cnt = 0;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", o_state); end
    checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b exp 0000", o_valid); end
    checks++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", o_cycle_count); end
    checks++; if ({o_pc_write, o_latch_en, o_latch_flush, o_done} !== 10'd0) begin
      errors++; $display("FAIL reset_comb: got %b exp 0", {o_pc_write, o_latch_en, o_latch_flush, o_done});
    end
    do_reset();
  endtask

  task automatic test_run10();
    logic [L-1:0] exp;
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL run_enter: got %0d exp 1", o_state); end
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (o_pc_write !== 1'b1) begin errors++; $display("FAIL run_pc[%0d]: got %b exp 1", i, o_pc_write); end
      tick();
      exp = (i < 4) ? L'((1 << (i + 1)) - 1) : 4'hF;
      checks++; if (o_valid !== exp) begin errors++; $display("FAIL run_valid[%0d]: got %b exp %b", i, o_valid, exp); end
    end
    checks++; if (o_cycle_count !== 32'd10) begin errors++; $display("FAIL run_count: got %0d exp 10", o_cycle_count); end
  endtask

  task automatic test_stall();
    set_in(1, 0, 0, 1, 0, 0);
    #1;
    checks++; if (o_latch_en !== 4'b1110) begin errors++; $display("FAIL stall_en: got %b exp 1110", o_latch_en); end
    checks++; if (o_latch_flush !== 4'b0010) begin errors++; $display("FAIL stall_flush: got %b exp 0010", o_latch_flush); end
    checks++; if (o_pc_write !== 1'b0) begin errors++; $display("FAIL stall_pc: got %b exp 0", o_pc_write); end
    tick();
    checks++; if (o_valid !== 4'b1101) begin errors++; $display("FAIL stall_valid: got %b exp 1101", o_valid); end
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (o_valid !== 4'b1111) begin errors++; $display("FAIL stall_refill: got %b exp 1111", o_valid); end
  endtask

  task automatic test_stall_flush();
    set_in(1, 0, 0, 1, 1, 0);
    #1;
    checks++; if (o_latch_flush !== 4'b0111) begin errors++; $display("FAIL sf_flush: got %b exp 0111", o_latch_flush); end
    checks++; if (o_latch_en !== 4'b1111) begin errors++; $display("FAIL sf_en: got %b exp 1111", o_latch_en); end
    checks++; if (o_pc_write !== 1'b1) begin errors++; $display("FAIL sf_pc: got %b exp 1", o_pc_write); end
    tick();
    checks++; if (o_valid !== 4'b1000) begin errors++; $display("FAIL sf_valid: got %b exp 1000", o_valid); end
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_halt_drain();
    logic [L-1:0] exp_v [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    set_in(1, 0, 0, 0, 0, 1);
    tick();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL halt_state: got %0d exp 3", o_state); end
    set_in(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_pc_write !== 1'b0) begin errors++; $display("FAIL drain_pc[%0d]: got %b exp 0", i, o_pc_write); end
      tick();
      checks++; if (o_valid !== exp_v[i]) begin errors++; $display("FAIL drain_valid[%0d]: got %b exp %b", i, o_valid, exp_v[i]); end
    end
    checks++; if (o_done !== 1'b1 || o_state !== 3'd4) begin
      errors++; $display("FAIL drain_done: got done=%b state=%0d exp done=1 state=4", o_done, o_state);
    end
    checks++; if (o_cycle_count !== 32'd25) begin errors++; $display("FAIL drain_count: got %0d exp 25", o_cycle_count); end
    #1;
    checks++; if (o_latch_en !== 4'b0000) begin errors++; $display("FAIL done_en: got %b exp 0000", o_latch_en); end
    tick();
    checks++; if (o_state !== 3'd4 || o_cycle_count !== 32'd25) begin
      errors++; $display("FAIL done_hold: got state=%0d cnt=%0d exp state=4 cnt=25", o_state, o_cycle_count);
    end
    set_in(0, 0, 1, 0, 0, 0);
    tick();
    checks++; if (o_state !== 3'd0 || o_cycle_count !== 32'd0 || o_valid !== 4'b0000) begin
      errors++; $display("FAIL clear: got state=%0d cnt=%0d valid=%b exp 0/0/0000", o_state, o_cycle_count, o_valid);
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_step();
    for (int n = 0; n < 3; n++) begin
      set_in(0, 1, 0, 0, 0, 0);
      tick();
      checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL step_state[%0d]: got %0d exp 2", n, o_state); end
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (o_pc_write !== 1'b1) begin errors++; $display("FAIL step_pc[%0d]: got %b exp 1", n, o_pc_write); end
      tick();
      checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL step_idle[%0d]: got %0d exp 0", n, o_state); end
      tick();
    end
    checks++; if (o_cycle_count !== 32'd3) begin errors++; $display("FAIL step_count: got %0d exp 3", o_cycle_count); end
    checks++; if (o_valid !== 4'b0111) begin errors++; $display("FAIL step_valid: got %b exp 0111", o_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
             ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 16) == 0);
      model_eval();
      #1;
      checks++; if ({o_pc_write, o_latch_en, o_latch_flush} !== {e_pc, e_en, e_fl}) begin
        errors++; $display("FAIL rnd_comb[%0d]: got %b exp %b", c, {o_pc_write, o_latch_en, o_latch_flush}, {e_pc, e_en, e_fl});
      end
      tick();
      m_state = n_state; m_valid = n_valid; m_cnt = n_cnt;
      checks++; if (o_state !== 3'(m_state) || o_done !== (m_state == 4)) begin
        errors++; $display("FAIL rnd_state[%0d]: got %0d exp %0d", c, o_state, m_state);
      end
      checks++; if (o_valid !== m_valid || o_cycle_count !== m_cnt) begin
        errors++; $display("FAIL rnd_regs[%0d]: got %b/%0d exp %b/%0d", c, o_valid, o_cycle_count, m_valid, m_cnt);
      end
      if (($urandom % 500) == 0) begin
        #2 rst = 1'b0;
        #1;
        checks++; if (o_state !== 3'd0 || o_valid !== 4'b0 || o_cycle_count !== 32'd0) begin
          errors++; $display("FAIL rnd_reset[%0d]: got %0d/%b/%0d exp 0/0000/0", c, o_state, o_valid, o_cycle_count);
        end
        rst = 1'b1;
        m_state = 0; m_valid = '0; m_cnt = 0;
      end
    end
  endtask

`ifdef PIPE_CTRL_BKPT_EN
  task automatic test_bkpt();
    bit hit;
    do_reset();
    i_fetch_pc = 0; i_bkpt_addr = 32'h10; i_bkpt_en = 1'b1;
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (o_state == 3'd0) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL bkpt_timeout: got no break exp break at 0x10"); end
    checks++; if (i_fetch_pc !== 32'h10 || o_bkpt_hit !== 1'b1 || o_cycle_count !== 32'd16) begin
      errors++; $display("FAIL bkpt_hit: got pc=%h hit=%b cnt=%0d exp 10/1/16", i_fetch_pc, o_bkpt_hit, o_cycle_count);
    end
    tick();
    checks++; if (o_bkpt_hit !== 1'b0 || o_state !== 3'd1) begin
      errors++; $display("FAIL bkpt_resume: got hit=%b state=%0d exp 0/1", o_bkpt_hit, o_state);
    end
    #1;
    checks++; if (o_pc_write !== 1'b1) begin errors++; $display("FAIL bkpt_pass: got %b exp 1", o_pc_write); end
    tick();
    checks++; if (i_fetch_pc !== 32'h11 || o_state !== 3'd1) begin
      errors++; $display("FAIL bkpt_past: got pc=%h state=%0d exp 11/1", i_fetch_pc, o_state);
    end
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    i_bkpt_en = 1'b0;
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_run10();
    test_stall();
    test_stall_flush();
    test_halt_drain();
    test_step();
`ifdef PIPE_CTRL_BKPT_EN
    test_bkpt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
